// File: rtl/lsu_pkg.sv
// +--------------------------------------------------------------------+
// | lsu_pkg: size encodings, FSM states and defaults for the LSU.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned DEFAULT_MEM_BYTES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_t;

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// +--------------------------------------------------------------------+
// | lsu_lane_align: big-endian lane extract/extend and lane merge.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Offset 0 is the most significant lane.
  always_comb begin
    w_byte = word_i[7:0];
    case (offset_i)
      2'd0:    w_byte = word_i[31:24];
      2'd1:    w_byte = word_i[23:16];
      2'd2:    w_byte = word_i[15:8];
      default: w_byte = word_i[7:0];
    endcase
    w_half = offset_i[1] ? word_i[15:0] : word_i[31:16];
  end

  always_comb begin
    load_o  = word_i;
    merge_o = word_i;
    case (size_i)
      SZ_BYTE: begin
        load_o = {{24{signed_i & w_byte[7]}}, w_byte};
        case (offset_i)
          2'd0:    merge_o[31:24] = wdata_i[7:0];
          2'd1:    merge_o[23:16] = wdata_i[7:0];
          2'd2:    merge_o[15:8]  = wdata_i[7:0];
          default: merge_o[7:0]   = wdata_i[7:0];
        endcase
      end
      SZ_HALF: begin
        load_o = {{16{signed_i & w_half[15]}}, w_half};
        if (offset_i[1]) merge_o[15:0]  = wdata_i[15:0];
        else             merge_o[31:16] = wdata_i[15:0];
      end
      default: begin
        load_o  = word_i;
        merge_o = word_i;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// +--------------------------------------------------------------------+
// | load_store_unit: byte/half/word accesses onto a word memory.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = DEFAULT_MEM_BYTES
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_fault_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_wenable_o,
  output logic        mem_renable_o,
  input  logic [31:0] mem_rdata_i
);

  lsu_state_t  state_q, state_d;
  logic        we_q, signed_q, fault_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, merge_q, rdata_q;

  logic        w_accept, w_fault;
  logic [32:0] w_last_byte;
  logic [31:0] w_load, w_merge;

  assign w_accept    = req_valid_i && (state_q == ST_IDLE);
  // 33 bits so addresses near 2^32 cannot wrap into range.
  assign w_last_byte = {1'b0, req_addr_i[31:2], 2'b00} + 33'd3;

  always_comb begin
    w_fault = 1'b0;
    if (req_size_i == 2'b11)                          w_fault = 1'b1;
    if (req_size_i == SZ_HALF && req_addr_i[0])       w_fault = 1'b1;
    if (req_size_i == SZ_WORD && |req_addr_i[1:0])    w_fault = 1'b1;
    if (w_last_byte >= 33'(MEM_BYTES))                w_fault = 1'b1;
  end

  lsu_lane_align u_align (
    .offset_i (addr_q[1:0]),
    .size_i   (size_q),
    .signed_i (signed_q),
    .word_i   (mem_rdata_i),
    .wdata_i  (wdata_q),
    .load_o   (w_load),
    .merge_o  (w_merge)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    req_ready_o   = 1'b0;
    resp_valid_o  = 1'b0;
    resp_fault_o  = 1'b0;
    resp_rdata_o  = '0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    mem_wenable_o = 1'b0;
    mem_renable_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (w_accept) begin
          if (w_fault)                                  state_d = ST_RESP;
          else if (req_we_i && req_size_i == SZ_WORD)   state_d = ST_WRITE;
          else                                          state_d = ST_READ;
        end
      end
      ST_READ: begin
        mem_addr_o    = {addr_q[31:2], 2'b00};
        mem_renable_o = 1'b1;
        state_d       = ST_WAIT;
      end
      ST_WAIT: begin
        mem_addr_o = {addr_q[31:2], 2'b00};
        state_d    = we_q ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        mem_addr_o    = {addr_q[31:2], 2'b00};
        mem_wenable_o = 1'b1;
        mem_wdata_o   = (size_q == SZ_WORD) ? wdata_q : merge_q;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        resp_valid_o = 1'b1;
        resp_fault_o = fault_q;
        // rdata_q may be stale from an earlier load; only a clean load shows it.
        resp_rdata_o = (!we_q && !fault_q) ? rdata_q : 32'd0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      fault_q  <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (w_accept) begin
        we_q     <= req_we_i;
        signed_q <= req_signed_i;
        fault_q  <= w_fault;
        size_q   <= req_size_i;
        addr_q   <= req_addr_i;
        wdata_q  <= req_wdata_i;
      end
      if (state_q == ST_WAIT) begin
        if (we_q) merge_q <= w_merge;
        else      rdata_q <= w_load;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// +--------------------------------------------------------------------+
// | tb_load_store_unit: directed + random bench with byte-array model. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int MEMB = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_fault, mem_wenable, mem_renable;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0, wr_cnt = 0, rv_cnt = 0;

  logic [31:0] mem [0:MEMB/4-1];
  logic [7:0]  ref_mem [0:MEMB-1];

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(MEMB)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_we_i      (req_we),
    .req_size_i    (req_size),
    .req_signed_i  (req_signed),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .resp_valid_o  (resp_valid),
    .resp_rdata_o  (resp_rdata),
    .resp_fault_o  (resp_fault),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_wenable_o (mem_wenable),
    .mem_renable_o (mem_renable),
    .mem_rdata_i   (mem_rdata)
  );

  // Word memory with registered read data.
  always @(posedge clk) begin
    if (mem_wenable) mem[mem_addr[9:2]] <= mem_wdata;
    if (mem_renable) mem_rdata <= mem[mem_addr[9:2]];
  end

  always @(negedge clk) begin
    if (mem_renable) rd_cnt <= rd_cnt + 1;
    if (mem_wenable) wr_cnt <= wr_cnt + 1;
    if (resp_valid)  rv_cnt <= rv_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
  endfunction

  function automatic bit ref_fault(input logic [1:0] sz, input logic [31:0] addr);
    longint last;
    last = longint'(addr) - longint'(addr % 4) + 3;
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b01 && (addr % 2) != 0) return 1'b1;
    if (sz == 2'b10 && (addr % 4) != 0) return 1'b1;
    return last >= MEMB;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sgn, input logic [31:0] addr);
    int a;
    logic [7:0] b;
    logic [15:0] h;
    a = int'(addr[9:0]);
    b = ref_mem[a];
    h = {ref_mem[a], ref_mem[a+1]};
    if (sz == 2'b00) return sgn ? {{24{b[7]}}, b} : {24'd0, b};
    if (sz == 2'b01) return sgn ? {{16{h[15]}}, h} : {16'd0, h};
    return ref_word(a);
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
    int a;
    a = int'(addr[9:0]);
    if (sz == 2'b00) ref_mem[a] = wd[7:0];
    else if (sz == 2'b01) begin
      ref_mem[a] = wd[15:8]; ref_mem[a+1] = wd[7:0];
    end else begin
      ref_mem[a] = wd[31:24]; ref_mem[a+1] = wd[23:16];
      ref_mem[a+2] = wd[15:8]; ref_mem[a+3] = wd[7:0];
    end
  endtask

  // One request: latency, data, fault, strobe counts and post-response idle.
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
    bit          f, got;
    int          n, lat, exp_lat, exp_rd, exp_wr, rd0, wr0;
    logic [31:0] exp_data, got_data;
    logic        got_fault;
    f        = ref_fault(sz, addr);
    exp_data = (f || we) ? 32'd0 : ref_load(sz, sgn, addr);
    exp_lat  = f ? 1 : (!we ? 3 : (sz == SZ_WORD ? 2 : 4));
    exp_rd   = (f || (we && sz == SZ_WORD)) ? 0 : 1;
    exp_wr   = (!f && we) ? 1 : 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
    req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    got = 1'b0; lat = 0; got_data = '0; got_fault = 1'b0;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1; lat = i; got_data = resp_rdata; got_fault = resp_fault;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_fault"}, 32'(got_fault), 32'(f));
    check({tag, "_rdata"}, got_data, exp_data);
    check({tag, "_rd_strobes"}, 32'(rd_cnt - rd0), 32'(exp_rd));
    check({tag, "_wr_strobes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    @(negedge clk);
    check({tag, "_pulse"}, {resp_valid, resp_fault, 30'd0}, 32'd0);
    check({tag, "_rdata_idle"}, resp_rdata, 32'd0);
    if (we && !f) begin
      ref_store(sz, addr, wd);
      check({tag, "_memword"}, mem[addr[9:2]], ref_word(int'({addr[9:2], 2'b00})));
    end
  endtask

  initial begin
    int          rd0, wr0, rv0;
    logic [11:0] rv_hist;
    logic [31:0] a, b2b_exp;
    for (int i = 0; i < MEMB/4; i++) begin
      mem[i] = 32'(i) * 32'h9E3779B9 + 32'h0000_1357;
      ref_mem[4*i]   = mem[i][31:24];
      ref_mem[4*i+1] = mem[i][23:16];
      ref_mem[4*i+2] = mem[i][15:8];
      ref_mem[4*i+3] = mem[i][7:0];
    end

    @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_resp", {resp_valid, resp_fault, mem_wenable, mem_renable, 28'd0}, 32'd0);
    check("reset_rdata", resp_rdata, 32'd0);
    check("reset_memaddr", mem_addr, 32'd0);
    check("reset_memwdata", mem_wdata, 32'd0);
    rst = 1'b0;

    do_req("st_word40", 1'b1, SZ_WORD, 1'b0, 32'h40, 32'hDEADBEEF);
    do_req("ld_word40", 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
    check("word_roundtrip_model", ref_word(32'h40), 32'hDEADBEEF);

    do_req("st_word20", 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11223344);
    do_req("st_byte21", 1'b1, SZ_BYTE, 1'b0, 32'h21, 32'hFFFF_FFAB);
    check("byte_merge_mem", mem[8], 32'h11AB3344);
    do_req("ld_sbyte21", 1'b0, SZ_BYTE, 1'b1, 32'h21, 32'h0);
    do_req("ld_ubyte21", 1'b0, SZ_BYTE, 1'b0, 32'h21, 32'h0);

    do_req("st_word30", 1'b1, SZ_WORD, 1'b0, 32'h30, 32'h8001_7FFF);
    do_req("ld_shalf30", 1'b0, SZ_HALF, 1'b1, 32'h30, 32'h0);
    do_req("ld_shalf32", 1'b0, SZ_HALF, 1'b1, 32'h32, 32'h0);
    do_req("ld_uhalf30", 1'b0, SZ_HALF, 1'b0, 32'h30, 32'h0);
    do_req("st_half32", 1'b1, SZ_HALF, 1'b0, 32'h32, 32'hAAAA_5AA5);
    check("half_merge_mem", mem[12], 32'h8001_5AA5);

    do_req("flt_word42", 1'b0, SZ_WORD, 1'b0, 32'h42, 32'h0);
    do_req("flt_half43", 1'b1, SZ_HALF, 1'b0, 32'h43, 32'h1234);
    do_req("flt_size11", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    do_req("flt_word400", 1'b0, SZ_WORD, 1'b0, 32'h400, 32'h0);
    do_req("ok_word3fc", 1'b0, SZ_WORD, 1'b0, 32'h3FC, 32'h0);
    do_req("ok_byte3ff", 1'b1, SZ_BYTE, 1'b0, 32'h3FF, 32'h5C);
    do_req("flt_wrap", 1'b0, SZ_BYTE, 1'b0, 32'hFFFF_FFFF, 32'h0);

    // Reset in the WAIT cycle of a byte store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_signed = 1'b0;
    req_addr = 32'h45; req_wdata = 32'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    rd0 = rd_cnt; wr0 = wr_cnt; rv0 = rv_cnt;
    repeat (2) @(negedge clk);
    check("rst_mid_memaddr", mem_addr, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    check("rst_mid_no_resp", 32'(rv_cnt - rv0), 32'd0);
    check("rst_mid_no_write", 32'(wr_cnt - wr0), 32'd0);
    check("rst_mid_no_read", 32'(rd_cnt - rd0), 32'd0);
    check("rst_mid_mem", mem[17], ref_word(32'h44));

    // Back-to-back: req_valid held through two word loads.
    b2b_exp = ref_word(32'h40);
    rv_hist = '0;
    rv0 = rv_cnt;
    req_we = 1'b0; req_size = SZ_WORD; req_signed = 1'b0; req_addr = 32'h40;
    check("b2b_start_ready", 32'(req_ready), 32'd1);
    for (int k = 0; k < 12; k++) begin
      rv_hist[k] = resp_valid;
      if (resp_valid) check("b2b_rdata", resp_rdata, b2b_exp);
      req_valid = (k < 8);
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b_pattern", 32'(rv_hist), 32'h088);
    check("b2b_count", 32'(rv_cnt - rv0), 32'd2);

    for (int i = 0; i < 80; i++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, MEMB - 1));
      do_req("rnd", 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
